// File: rtl/sd_port.sv
// CPU I/O-port front end for the SD SPI sector engine.
// Holds the sector buffer and LBA registers and sequences one-sector commands.
module sd_port #(
  parameter int BUSY_TMO = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  port_a,
  input  logic        port_rd,
  input  logic        port_wr,
  input  logic [7:0]  port_i,
  output logic [7:0]  port_o,
  output logic        irq,
  output logic        sd_command,
  output logic        sd_rw,
  output logic [31:0] sd_lba,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic [3:0]  sd_error,
  input  logic [1:0]  sd_card,
  input  logic [8:0]  sd_a,
  input  logic [7:0]  sd_o,
  input  logic        sd_w,
  output logic [7:0]  sd_i
);

  localparam int CW = $clog2(BUSY_TMO + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAITB, RUN, FIN
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [512];
  logic [31:0]   lba;
  logic [8:0]    ptr;
  logic [3:0]    err;
  logic [CW-1:0] cnt;
  logic          ready, pend, ien, busy;
  logic          rd_en, wr_reg, rd_dat, wr_dat, cmd_ok;

  assign busy       = (state != IDLE);
  assign irq        = pend & ien;
  assign sd_lba     = lba;
  assign sd_command = (state == ISSUE);

  // A simultaneous write wins; the read is dropped.
  assign rd_en  = port_rd & ~port_wr;
  assign wr_reg = port_wr & ~busy;
  assign rd_dat = rd_en & ~busy & (port_a == 3'd6);
  assign wr_dat = wr_reg & (port_a == 3'd6);
  assign cmd_ok = wr_reg & (port_a == 3'd4)
                & ((port_i == 8'h01) | (port_i == 8'h02));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_ok) state_nx = ISSUE;
      ISSUE:   state_nx = WAITB;
      WAITB: begin
        if (sd_busy)         state_nx = RUN;
        else if (cnt == '0)  state_nx = FIN;
      end
      RUN:     if (sd_done || !sd_busy) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      port_o <= '0;
      sd_rw  <= 1'b0;
      lba    <= '0;
      ptr    <= '0;
      err    <= '0;
      cnt    <= '0;
      ready  <= 1'b0;
      pend   <= 1'b0;
      ien    <= 1'b0;
    end else begin
      if (wr_reg && !port_a[2])
        lba[{port_a[1:0], 3'b000} +: 8] <= port_i;
      if (cmd_ok) begin
        sd_rw <= port_i[1];
        ready <= 1'b0;
        err   <= '0;
        ptr   <= '0;
      end
      if (wr_dat || rd_dat) ptr <= ptr + 9'd1;
      if (port_wr && port_a == 3'd7) begin
        ptr  <= '0;
        ien  <= port_i[1];
        pend <= 1'b0;
      end
      if (rd_en) begin
        case (port_a)
          3'd4:    port_o <= {busy, ready, err != 4'h0,
                              pend, sd_card, 2'b00};
          3'd5:    port_o <= {ptr[8], 3'b000, err};
          3'd6:    port_o <= busy ? 8'hFF : mem[ptr];
          3'd7:    port_o <= ptr[7:0];
          default: port_o <= lba[{port_a[1:0], 3'b000} +: 8];
        endcase
      end
      case (state)
        ISSUE: cnt <= CW'(BUSY_TMO);
        WAITB: begin
          if (!sd_busy) begin
            if (cnt == '0) err <= 4'hF;
            else           cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (sd_done) begin
            ready <= ~sd_rw;
            err   <= '0;
          end else if (!sd_busy) begin
            err <= (sd_error != 4'h0) ? sd_error : 4'hE;
          end
        end
        // Completion outranks a same-cycle pend clear.
        FIN:     pend <= 1'b1;
        default: ;
      endcase
    end
  end

  // CPU data access is locked out while busy, so the two
  // write sources never collide on one address.
  always_ff @(posedge clock) begin
    if (wr_dat) mem[ptr] <= port_i;
    if (sd_w)   mem[sd_a] <= sd_o;
    sd_i <= mem[sd_a];
  end

endmodule

// File: tb/tb_sd_port.sv
// Directed bench for sd_port with scoreboard queues
// for CPU reads and engine buffer reads.
module tb_sd_port;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  port_a = '0;
  logic        port_rd = 1'b0;
  logic        port_wr = 1'b0;
  logic [7:0]  port_i = '0;
  logic [7:0]  port_o;
  logic        irq;
  logic        sd_command;
  logic        sd_rw;
  logic [31:0] sd_lba;
  logic        sd_busy = 1'b0;
  logic        sd_done = 1'b0;
  logic [3:0]  sd_error = '0;
  logic [1:0]  sd_card = '0;
  logic [8:0]  sd_a = '0;
  logic [7:0]  sd_o = '0;
  logic        sd_w = 1'b0;
  logic [7:0]  sd_i;

  int checks = 0;
  int errors = 0;
  int cmd_cnt = 0;
  logic [7:0] rd_q [$];
  logic [7:0] sdi_q [$];

  sd_port #(.BUSY_TMO(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .port_a(port_a), .port_rd(port_rd),
    .port_wr(port_wr), .port_i(port_i),
    .port_o(port_o), .irq(irq),
    .sd_command(sd_command), .sd_rw(sd_rw),
    .sd_lba(sd_lba), .sd_busy(sd_busy),
    .sd_done(sd_done), .sd_error(sd_error),
    .sd_card(sd_card), .sd_a(sd_a),
    .sd_o(sd_o), .sd_w(sd_w), .sd_i(sd_i)
  );

  always #20 clock = ~clock;

  always @(posedge clock)
    if (sd_command === 1'b1) cmd_cnt++;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    port_a  = a;
    port_i  = d;
    port_wr = 1'b1;
    tick();
    port_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [7:0] exp);
    port_a  = a;
    port_rd = 1'b1;
    rd_q.push_back(exp);
    tick();
    port_rd = 1'b0;
    check(tag, port_o, rd_q.pop_front());
  endtask

  initial begin
    repeat (3) tick();
    check("rst_port_o", port_o, 0);
    check("rst_irq", irq, 0);
    check("rst_cmd", sd_command, 0);
    check("rst_rw", sd_rw, 0);
    check("rst_lba", sd_lba, 0);
    reset_n = 1'b1;
    tick();
    rd("rst_status", 3'd4, 8'h00);

    // read command
    wr(3'd0, 8'h78);
    wr(3'd1, 8'h56);
    wr(3'd2, 8'h34);
    wr(3'd3, 8'h12);
    check("lba", sd_lba, 32'h12345678);
    rd("lba_b2", 3'd2, 8'h34);
    wr(3'd7, 8'h02);
    wr(3'd4, 8'h01);
    check("rd_rw", sd_rw, 0);
    rd("busy_status", 3'd4, 8'h80);
    sd_busy = 1'b1;
    tick();
    check("one_pulse", cmd_cnt, 1);

    // lockout while busy
    wr(3'd0, 8'hFF);
    wr(3'd6, 8'h00);
    rd("busy_data", 3'd6, 8'hFF);
    rd("busy_ptr", 3'd7, 8'h00);
    wr(3'd4, 8'h01);
    check("busy_lba", sd_lba, 32'h12345678);
    tick();
    check("no_2nd_pulse", cmd_cnt, 1);

    for (int k = 0; k < 512; k++) begin
      sd_a = 9'(k);
      sd_o = 8'(k) ^ 8'hA5;
      sd_w = 1'b1;
      tick();
    end
    sd_w = 1'b0;
    sd_card = 2'b10;
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    sd_busy = 1'b0;
    tick();
    rd("done_status", 3'd4, 8'h58);
    check("done_irq", irq, 1);
    for (int k = 0; k < 512; k++)
      rd("rd_data", 3'd6, 8'(k) ^ 8'hA5);
    rd("rd_wrap", 3'd6, 8'hA5);
    rd("ptr_after", 3'd7, 8'h01);

    // engine error
    wr(3'd7, 8'h02);
    check("pend_clr_irq", irq, 0);
    wr(3'd4, 8'h01);
    sd_busy = 1'b1;
    tick();
    tick();
    sd_error = 4'h7;
    sd_busy  = 1'b0;
    tick();
    tick();
    sd_error = 4'h0;
    rd("err_status", 3'd4, 8'h38);
    rd("err_code", 3'd5, 8'h07);
    check("err_irq", irq, 1);

    // busy timeout
    wr(3'd7, 8'h02);
    wr(3'd4, 8'h01);
    repeat (10) tick();
    rd("tmo_fin", 3'd4, 8'hA8);
    rd("tmo_status", 3'd4, 8'h38);
    rd("tmo_code", 3'd5, 8'h0F);
    check("tmo_pulses", cmd_cnt, 3);

    wr(3'd7, 8'h02);
    wr(3'd4, 8'h01);
    sd_busy = 1'b1;
    tick();
    tick();
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    sd_busy = 1'b0;
    tick();
    rd("retry_status", 3'd4, 8'h58);
    check("retry_pulses", cmd_cnt, 4);

    // write path
    wr(3'd7, 8'h02);
    for (int k = 0; k < 512; k++)
      wr(3'd6, 8'(k * 7 + 3));
    rd("wr_ptr", 3'd7, 8'h00);
    rd("wr_ptr_hi", 3'd5, 8'h00);
    wr(3'd4, 8'h02);
    check("wr_rw", sd_rw, 1);
    sd_busy = 1'b1;
    tick();
    tick();
    for (int k = 511; k >= 0; k--) begin
      sd_a = 9'(k);
      sdi_q.push_back(8'(k * 7 + 3));
      tick();
      check("sd_i", sd_i, sdi_q.pop_front());
    end

    // reset mid-RUN
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sd_busy = 1'b0;
    sd_card = 2'b00;
    tick();
    rd("mid_rst_status", 3'd4, 8'h00);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_rw", sd_rw, 0);
    check("mid_rst_lba", sd_lba, 0);
    repeat (3) tick();
    check("mid_rst_pulses", cmd_cnt, 5);

    // write wins over simultaneous read
    port_a  = 3'd0;
    port_i  = 8'h11;
    port_wr = 1'b1;
    port_rd = 1'b1;
    rd_q.push_back(8'h00);
    tick();
    port_wr = 1'b0;
    port_rd = 1'b0;
    check("rdwr_port_o", port_o, rd_q.pop_front());
    rd("rdwr_lba", 3'd0, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_port.md
Name: sd_port

Overview:
- CPU-facing I/O-port front end for the SD SPI sector engine.
- Holds a 512-byte dual-port sector buffer and the LBA registers, issues single-sector read/write commands to the engine, and collects engine status.
- The engine's buffer-write bus (a/o/w) and write-data input (i) connect directly to this block.
- Sits between the i386 port decoder and the SD engine.

Parameters:
- BUSY_TMO, 8, cycles allowed between the sd_command pulse and sd_busy rising before error 4'hF is reported.

Ports:
- clock  in  1  system clock, 25 MHz
- reset_n  in  1  reset, synchronous, active-low
- port_a  in  3  register select
- port_rd  in  1  read strobe, one cycle per access
- port_wr  in  1  write strobe, one cycle per access
- port_i  in  8  CPU write data
- port_o  out  8  CPU read data, registered
- irq  out  1  completion interrupt, level
- sd_command  out  1  one-cycle start pulse to the engine
- sd_rw  out  1  0 = read, 1 = write
- sd_lba  out  32  sector number, stable while a command is active
- sd_busy  in  1  engine busy
- sd_done  in  1  engine success strobe
- sd_error  in  4  engine error code
- sd_card  in  2  engine card type
- sd_a  in  9  engine buffer address
- sd_o  in  8  engine byte to store
- sd_w  in  1  engine store strobe
- sd_i  out  8  buffer[sd_a], one-cycle read latency

Behaviour:
- Reset: port_o=0, irq=0, sd_command=0, sd_rw=0, lba=0, ptr=0, err=0, ready=0, pend=0, ien=0, state=IDLE. Buffer contents are undefined after reset.
- Register map, write side (port_wr):
  - 0..3: LBA bytes 0..3, little-endian.
  - 4: command. 8'h01 = read sector, 8'h02 = write sector; any other value is ignored.
  - 6: data. buffer[ptr] <= port_i; ptr <= ptr+1.
  - 7: control. ptr <= 0; ien <= port_i[1]; pend <= 0.
- Register map, read side (port_rd; port_o updated on the next edge):
  - 0..3: LBA bytes.
  - 4: status = {busy, ready, err!=0, pend, sd_card, 2'b00}.
  - 5: {ptr[8], 3'b0, err}.
  - 6: data. port_o <= buffer[ptr]; ptr <= ptr+1.
  - 7: ptr[7:0].
- Back-to-back data accesses are allowed every cycle. ptr wraps 511 -> 0.
- port_rd and port_wr asserted together: the write is performed and the read is ignored.
- busy = (state != IDLE).
- While busy:
  - Writes to registers 0-4 and 6 are ignored.
  - Data reads return 8'hFF and leave ptr unchanged.
  - Register 7 still works.
- irq = pend & ien.
- Engine side:
  - Buffer port B is addressed by sd_a.
  - An sd_w store and a CPU access to the same address in the same cycle cannot happen, because CPU data access is blocked while busy.
- State machine:
  - IDLE: on a valid command: sd_rw <= cmd[1]; ready <= 0; err <= 0; ptr <= 0; go to ISSUE.
  - ISSUE: sd_command=1 for exactly this cycle; load the timeout counter with BUSY_TMO; go to WAITB.
  - WAITB:
    - If sd_busy -> RUN.
    - Else if the counter reaches 0 -> err <= 4'hF, go to FIN.
    - Else decrement the counter.
  - RUN:
    - If sd_done -> ready <= ~sd_rw, err <= 0, go to FIN. sd_done takes priority over sd_busy falling in the same cycle.
    - Else if !sd_busy -> err <= (sd_error ? sd_error : 4'hE), go to FIN.
  - FIN: pend <= 1; go to IDLE.
- sd_lba presents the latched LBA registers at all times. They cannot change while busy.
- A reset mid-operation returns to IDLE with all outputs at reset values, no further sd_command is issued, and the engine is reset by the same reset_n.

Test Plan:
- Write LBA regs 0..3 = 78,56,34,12, then write reg 4 = 01 -> sd_lba = 32'h12345678, sd_rw = 0, exactly one sd_command pulse, status bit7 = 1 on the next read.
- Engine model asserts busy, stores bytes k = k^8'hA5 at sd_a = 0..511, pulses done -> status = 8'h50|card<<2 (ready, pend); with ien = 1, irq = 1; 512 reads of reg 6 return k^8'hA5 in order; the 513th read returns buffer[0].
- Engine drops busy without done, sd_error = 7 -> status bit5 = 1, reg 5 low nibble = 7, ready = 0, pend = 1.
- Engine never raises busy -> FIN after BUSY_TMO+1 cycles with err = F; a second command is then accepted normally.
- While busy: write reg 0 = FF and reg 6 = 00, read reg 6 -> LBA unchanged, port_o = FF, ptr unchanged; command 01 is ignored (no second pulse).
- Load 512 bytes via reg 6, command 02 -> sd_rw = 1; sd_i equals the loaded byte one cycle after each sd_a; a reset_n pulse mid-RUN gives status 00 and irq 0.
